// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam logic [31:0] MEM_ADDR_IDLE = 32'h0000_0000;

   function automatic int index_width(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int word_width(input int words);
      return $clog2(words);
   endfunction

   // Whatever is left of the 30-bit word address above index and word offset.
   function automatic int tag_width(input int lines, input int words);
      return 30 - index_width(lines) - word_width(words);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for icache_dm: combinational read port,
// one data-word write port, a tag/valid write and a global valid clear.
module icache_array
   import icache_pkg::*;
#(
   parameter  int LINES = 16,
   parameter  int WORDS = 4,
   localparam int IW    = index_width(LINES),
   localparam int WW    = word_width(WORDS),
   localparam int TW    = tag_width(LINES, WORDS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [IW-1:0] rd_index,
   input  logic [WW-1:0] rd_word,
   output logic          rd_valid,
   output logic [TW-1:0] rd_tag,
   output logic [31:0]   rd_data,
   input  logic [IW-1:0] wr_index,
   input  logic          data_we,
   input  logic [WW-1:0] wr_word,
   input  logic [31:0]   wr_data,
   input  logic          tag_we,
   input  logic [TW-1:0] wr_tag,
   input  logic          valid_clear
);

   logic [31:0]    data_mem [LINES][WORDS];
   logic [TW-1:0]  tag_mem  [LINES];
   logic [LINES-1:0] valid;

   // NOTE: storage arrays carry no reset; only the valid bits need a known state.
   always_ff @(posedge clock) begin
      if (data_we) data_mem[wr_index][wr_word] <= wr_data;
      if (tag_we)  tag_mem[wr_index]           <= wr_tag;
   end

   // A clear on the same edge as a line completion leaves the line invalid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)            valid           <= '0;
      else if (valid_clear) valid           <= '0;
      else if (tag_we)      valid[wr_index] <= 1'b1;
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with burst line fill from a synchronous RAM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm
   import icache_pkg::*;
#(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_instr,
   output logic        hold,
   input  logic        flush,
   output logic [31:0] mem_addr,
   output logic        mem_ce_n,
   output logic        mem_oe_n,
   input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IW = index_width(LINES);
   localparam int WW = word_width(WORDS);
   localparam int TW = tag_width(LINES, WORDS);

   state_t        state, state_nxt;
   logic [WW:0]   req_cnt;
   logic [WW-1:0] rsp_cnt;
   logic [TW-1:0] tag_q;
   logic [IW-1:0] index_q;

   logic [TW-1:0] cpu_tag;
   logic [IW-1:0] cpu_index;
   logic [WW-1:0] cpu_word;
   logic          rd_valid;
   logic [TW-1:0] rd_tag;
   logic [31:0]   rd_data;
   logic          hit, miss, req_phase, data_we, last_write;
   logic          unused_bits;

   assign cpu_tag     = cpu_addr[31 -: TW];
   assign cpu_index   = cpu_addr[2+WW +: IW];
   assign cpu_word    = cpu_addr[2 +: WW];
   assign unused_bits = &{1'b0, cpu_addr[1:0]};

   assign hit        = cpu_req && rd_valid && (rd_tag == cpu_tag);
   assign miss       = (state == IDLE) && cpu_req && !hit;
   assign req_phase  = req_cnt < (WW+1)'(WORDS);
   // The first FILL cycle only issues a request; responses trail by one cycle.
   assign data_we    = (state == FILL) && (req_cnt != '0);
   assign last_write = data_we && (rsp_cnt == WW'(WORDS - 1));

   icache_array #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_array (
      .clock       (clock),
      .reset       (reset),
      .rd_index    (cpu_index),
      .rd_word     (cpu_word),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_data     (rd_data),
      .wr_index    (index_q),
      .data_we     (data_we),
      .wr_word     (rsp_cnt),
      .wr_data     (mem_data),
      .tag_we      (last_write),
      .wr_tag      (tag_q),
      .valid_clear (flush)
   );

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      hold      = 1'b0;
      cpu_instr = '0;
      mem_ce_n  = 1'b1;
      mem_oe_n  = 1'b1;
      mem_addr  = MEM_ADDR_IDLE;
      unique case (state)
         IDLE: begin
            if (cpu_req) begin
               if (hit) begin
                  cpu_instr = rd_data;
               end else begin
                  hold      = 1'b1;
                  state_nxt = FILL;
               end
            end
         end
         FILL: begin
            hold = 1'b1;
            if (req_phase) begin
               mem_ce_n = 1'b0;
               mem_oe_n = 1'b0;
               mem_addr = {tag_q, index_q, req_cnt[WW-1:0], 2'b00};
            end
            if (last_write) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Keep the core unstalled while reset is held, even with a fetch pending.
      if (reset) hold = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         req_cnt <= '0;
         rsp_cnt <= '0;
         tag_q   <= '0;
         index_q <= '0;
      end else begin
         state <= state_nxt;
         if (miss) begin
            tag_q   <= cpu_tag;
            index_q <= cpu_index;
            req_cnt <= '0;
            rsp_cnt <= '0;
         end else if (state == FILL) begin
            if (req_phase) req_cnt <= req_cnt + 1'b1;
            if (data_we)   rsp_cnt <= rsp_cnt + 1'b1;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if ((state == IDLE) && hit) hit_count  <= hit_count + 32'd1;
         if (miss)                   miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: behavioural cache model checked every cycle
// plus directed fetch sequences with literal expectations.
module tb_icache_dm;

   localparam int LINES = 16;
   localparam int WORDS = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_instr;
   logic        hold;
   logic        flush = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_ce_n;
   logic        mem_oe_n;
   logic [31:0] mem_data = '0;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int n_checks = 0;
   int n_err    = 0;

   icache_dm #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_instr (cpu_instr),
      .hold      (hold),
      .flush     (flush),
      .mem_addr  (mem_addr),
      .mem_ce_n  (mem_ce_n),
      .mem_oe_n  (mem_oe_n),
      .mem_data  (mem_data)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM contents: each word is the bitwise complement of its byte address.
   function automatic logic [31:0] ram_fn(input logic [31:0] a);
      return ~{a[31:2], 2'b00};
   endfunction

   // Synchronous RAM: data for the address of cycle n appears during cycle n+1.
   always @(posedge clock) begin
      if (!mem_ce_n && !mem_oe_n) mem_data <= ram_fn(mem_addr);
      else                        mem_data <= 32'hDEAD_BEEF;
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   int          fill_left = 0;
   int          fill_line = 0;
   logic [31:0] fill_tag  = '0;
   logic [31:0] fill_base = '0;
   int unsigned m_hits = 0;
   int unsigned m_misses = 0;

   always @(negedge clock) begin
      int ln;
      int k;
      bit is_hit;
      if (reset) begin
         check("rst_hold", {31'b0, hold}, 32'd0);
         check("rst_instr", cpu_instr, 32'd0);
         check("rst_ce_n", {31'b0, mem_ce_n}, 32'd1);
         check("rst_oe_n", {31'b0, mem_oe_n}, 32'd1);
         check("rst_addr", mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
         check("rst_hits", hit_count, 32'd0);
         check("rst_misses", miss_count, 32'd0);
`endif
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         fill_left = 0;
         m_hits    = 0;
         m_misses  = 0;
      end else begin
`ifdef ICACHE_STATS_EN
         check("hit_count", hit_count, m_hits);
         check("miss_count", miss_count, m_misses);
`endif
         if (fill_left == 0) begin
            check("idle_ce_n", {31'b0, mem_ce_n}, 32'd1);
            check("idle_oe_n", {31'b0, mem_oe_n}, 32'd1);
            check("idle_addr", mem_addr, 32'd0);
            if (cpu_req) begin
               ln     = int'((cpu_addr / 16) % LINES);
               is_hit = m_valid[ln] && (m_tag[ln] == cpu_addr / 256);
               check("lookup_hold", {31'b0, hold}, {31'b0, !is_hit});
               if (is_hit) begin
                  check("hit_instr", cpu_instr, ram_fn(cpu_addr));
                  m_hits++;
               end else begin
                  fill_left = WORDS + 1;
                  fill_line = ln;
                  fill_tag  = cpu_addr / 256;
                  fill_base = cpu_addr - (cpu_addr % 16);
                  m_misses++;
               end
            end else begin
               check("noreq_hold", {31'b0, hold}, 32'd0);
               check("noreq_instr", cpu_instr, 32'd0);
            end
         end else begin
            k = WORDS + 1 - fill_left;
            check("fill_hold", {31'b0, hold}, 32'd1);
            if (k < WORDS) begin
               check("fill_ce_n", {31'b0, mem_ce_n}, 32'd0);
               check("fill_oe_n", {31'b0, mem_oe_n}, 32'd0);
               check("fill_addr", mem_addr, fill_base + 32'(4 * k));
            end else begin
               check("tail_ce_n", {31'b0, mem_ce_n}, 32'd1);
               check("tail_addr", mem_addr, 32'd0);
            end
            fill_left--;
            if (fill_left == 0) begin
               m_valid[fill_line] = 1'b1;
               m_tag[fill_line]   = fill_tag;
            end
         end
         if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
   end

   // Record every RAM request address for the burst-order checks.
   logic [31:0] addr_q[$];
   always @(negedge clock) begin
      if (!reset && !mem_ce_n) addr_q.push_back(mem_addr);
   end

   // ---------------- directed stimulus ----------------
   // Called at posedge+1; returns at posedge+1 after one idle cycle.
   task automatic do_fetch(input logic [31:0] a, output int stalls, output logic [31:0] instr);
      cpu_addr = a;
      cpu_req  = 1'b1;
      stalls   = 0;
      @(negedge clock);
      while (hold && stalls < 50) begin
         stalls++;
         @(negedge clock);
      end
      if (hold) check("hold_timeout", {31'b0, hold}, 32'd0);
      instr = cpu_instr;
      @(posedge clock);
      #1;
      cpu_req  = 1'b0;
      cpu_addr = '0;
      @(posedge clock);
      #1;
   endtask

   task automatic flush_after(input int n);
      repeat (n) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
   endtask

   initial begin
      int          st;
      logic [31:0] ins;
      logic [31:0] exp_burst [4];
      exp_burst[0] = 32'h0040_0000;
      exp_burst[1] = 32'h0040_0004;
      exp_burst[2] = 32'h0040_0008;
      exp_burst[3] = 32'h0040_000C;

      #1;
      check("init_hold", {31'b0, hold}, 32'd0);
      check("init_ce_n", {31'b0, mem_ce_n}, 32'd1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;

      // Cold miss: 6-cycle stall, sequential burst, then the first word.
      addr_q.delete();
      do_fetch(32'h0040_0000, st, ins);
      check("cold_stalls", st, 32'd6);
      check("cold_instr", ins, 32'hFFBF_FFFF);
      check("burst_len", addr_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++) check("burst_addr", addr_q[i], exp_burst[i]);

      // Same line, last word: zero-latency hit.
      do_fetch(32'h0040_000C, st, ins);
      check("hit_stalls", st, 32'd0);
      check("hit_instr_lit", ins, 32'hFFBF_FFF3);

      // Conflict on index 0 evicts, then the original misses again.
      do_fetch(32'h0040_0100, st, ins);
      check("conflict_stalls", st, 32'd6);
      check("conflict_instr", ins, 32'hFFBF_FEFF);
      do_fetch(32'h0040_0000, st, ins);
      check("evicted_stalls", st, 32'd6);

      // Flush invalidates a resident line.
      flush_after(0);
      do_fetch(32'h0040_0004, st, ins);
      check("flushed_stalls", st, 32'd6);
      check("flushed_instr", ins, 32'hFFBF_FFFB);

      // Flush early in a fill does not stop the line becoming valid.
      fork
         do_fetch(32'h0040_0010, st, ins);
         flush_after(1);
      join
      check("early_flush_stalls", st, 32'd6);
      do_fetch(32'h0040_0014, st, ins);
      check("early_flush_hit", st, 32'd0);
      check("early_flush_instr", ins, 32'hFFBF_FFEB);

      // Flush on the final write wins; the retry misses back-to-back.
      fork
         do_fetch(32'h0040_0020, st, ins);
         flush_after(5);
      join
      check("late_flush_stalls", st, 32'd12);
      check("late_flush_instr", ins, 32'hFFBF_FFDF);
      do_fetch(32'h0040_0020, st, ins);
      check("late_flush_hit", st, 32'd0);

      // Reset during the third FILL cycle.
      cpu_addr = 32'h0040_0200;
      cpu_req  = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("midrst_hold", {31'b0, hold}, 32'd0);
      check("midrst_ce_n", {31'b0, mem_ce_n}, 32'd1);
      check("midrst_oe_n", {31'b0, mem_oe_n}, 32'd1);
      check("midrst_addr", mem_addr, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      do_fetch(32'h0040_0200, st, ins);
      check("postrst_stalls", st, 32'd6);
      check("postrst_instr", ins, 32'hFFBF_FDFF);

`ifdef ICACHE_STATS_EN
      // miss (retry hit), two more hits, then a second miss.
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      do_fetch(32'h0040_0000, st, ins);
      do_fetch(32'h0040_0004, st, ins);
      do_fetch(32'h0040_0008, st, ins);
      cpu_addr = 32'h0040_0100;
      cpu_req  = 1'b1;
      @(posedge clock);
      #1;
      check("stats_hits", hit_count, 32'd3);
      check("stats_misses", miss_count, 32'd2);
      do_fetch(32'h0040_0100, st, ins);
`endif

      repeat (2) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
